aes_kat_sequencer: RTL
======================

Name: aes_kat_sequencer

Overview:
Sequences a known-answer and side-channel sweep over the AES core. Per vector, the block:
- steps the registered test-vector source (plaintext/key generator with `ena`/`reset`);
- launches one AES encryption and raises a scope trigger around it;
- waits for completion with a timeout;
- hands the ciphertext to a downstream logger (UART/capture FIFO) over a valid/ready handshake;
- waits a programmable quiet gap before the next vector.

It sits between the host start control, the vector source, the AES core and the result sink.

Parameters:
- TIMEOUT, 1024, max cycles to wait for aes_done after aes_start before aborting the sweep.
- GAP_CYCLES, 16, idle cycles between result acceptance and the next vector load (trace separation); 0 is legal.
- TRIG_HOLD, 4, cycles trig stays high starting with the aes_start cycle; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  start-sweep pulse; sampled only in IDLE
- abort  in  1  synchronous abort, any state
- num_vectors  in  8  vectors per sweep, sampled at run; 0 or >128 means 128
- gen_clr  out  1  one-cycle pulse clearing the vector source index
- gen_ena  out  1  one-cycle pulse advancing the vector source
- aes_start  out  1  one-cycle encryption launch
- aes_done  in  1  core completion pulse
- aes_ct  in  128  core ciphertext, valid with aes_done
- res_valid  out  1  result available
- res_ready  in  1  sink accepts result
- res_data  out  128  captured ciphertext
- res_idx  out  7  vector index of res_data, 0-based
- trig  out  1  scope trigger
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sweep end (normal or timeout)
- timeout_err  out  1  sticky; cleared by reset or the next accepted run

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- States:
  - IDLE: on run → CLR; latch the count; clear timeout_err.
  - CLR: gen_clr=1 → LOAD.
  - LOAD: gen_ena=1 → SETTLE. The source registers its outputs on ena, so data is valid the cycle after LOAD.
  - SETTLE: one cycle → START.
  - START: aes_start=1; trig rises the same cycle → WAIT.
  - WAIT:
    - on aes_done: latch res_data=aes_ct and res_idx=current index → OUT.
    - otherwise the wait counter increments; when it reaches TIMEOUT → set timeout_err, go to FIN.
  - OUT: res_valid=1; res_data/res_idx held stable until res_valid&&res_ready. On that handshake:
    - if last vector → FIN;
    - else index+1 → GAP, or → LOAD when GAP_CYCLES=0.
  - GAP: count GAP_CYCLES cycles → LOAD.
  - FIN: done=1 → IDLE.
- aes_done is sampled only in WAIT; pulses in any other state are ignored.
- Latency: run accepted at cycle 0; gen_clr at cycle 1, gen_ena at cycle 2, aes_start at cycle 4.
- Same-cycle handshake: res_valid drops the cycle after the handshake. If res_ready is already high on OUT entry, the transfer completes in one cycle.
- trig:
  - high for exactly TRIG_HOLD cycles from the aes_start cycle;
  - independent of state after that, but forced low by abort;
  - if aes_done arrives before TRIG_HOLD expires, trig still completes its hold.
- Index: 7-bit, counts 0..N-1, no wrap inside a sweep. With N=128, the last index is 127 and the sweep ends at FIN; the index is not incremented past 127.
- run while busy: ignored.
- abort: next state IDLE.
  - res_valid, trig and busy go low the following cycle.
  - No done pulse; timeout_err unchanged.
  - Abort has priority over every other transition, including a same-cycle aes_done or handshake.
- Reset mid-sweep: immediate return to reset values. The vector source is cleared by gen_clr at the next run, not by this block's reset.
- Timeout: no result is emitted for the timed-out vector.

Test Plan:
1. num_vectors=3, GAP_CYCLES=16, aes_done 10 cycles after each aes_start, res_ready=1:
   → one gen_clr, 3 gen_ena, 3 aes_start;
   → res_idx 0,1,2 with res_data equal to each aes_ct;
   → one done; timeout_err=0; first aes_start at cycle 4 after run.
2. num_vectors=0 → exactly 128 results, last res_idx=127, then done; no 129th gen_ena.
3. Backpressure: res_ready low 20 cycles on vector 1 → res_valid held and res_data/res_idx stable throughout; no gen_ena until the handshake plus GAP_CYCLES.
4. aes_done never asserted → timeout_err=1 and done pulse exactly TIMEOUT cycles after entering WAIT (end of the WAIT count), no res_valid. A subsequent run clears timeout_err.
5. abort asserted in WAIT together with aes_done → IDLE next cycle, no res_valid, no done. run mid-sweep → ignored, index sequence unchanged.
6. Async reset asserted during OUT → all outputs 0 immediately. A new run after release restarts at res_idx 0 with gen_clr pulsed.

Source files
------------

// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: runs a KAT / side-channel sweep over the AES core.
// Steps the vector source, launches AES, and hands ciphertexts to the logger.
module aes_kat_sequencer #(
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 16,
  parameter int TRIG_HOLD  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         abort,
  input  logic [7:0]   num_vectors,
  output logic         gen_clr,
  output logic         gen_ena,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_ct,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic [6:0]   res_idx,
  output logic         trig,
  output logic         busy,
  output logic         done,
  output logic         timeout_err
);

  localparam int CW = $clog2(TIMEOUT + GAP_CYCLES + 2);
  localparam int TW = $clog2(TRIG_HOLD + 1);

  typedef enum logic [3:0] {
    IDLE, CLR, LOAD, SETTLE, START, WAIT, OUT, GAP, FIN
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [6:0]    idx;
  logic [6:0]    last;
  logic          hs;
  logic          last_v;
  logic          wait_to;
  logic          gap_end;

  assign hs      = (state == OUT) && res_ready;
  assign last_v  = (idx == last);
  assign wait_to = (cnt == CW'(TIMEOUT - 1));
  assign gap_end = (cnt == CW'(GAP_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (run) state_nx = CLR;
      CLR:    state_nx = LOAD;
      LOAD:   state_nx = SETTLE;
      SETTLE: state_nx = START;
      START:  state_nx = WAIT;
      WAIT: begin
        if (aes_done)     state_nx = OUT;
        else if (wait_to) state_nx = FIN;
      end
      OUT: begin
        if (res_ready) begin
          if (last_v)               state_nx = FIN;
          else if (GAP_CYCLES == 0) state_nx = LOAD;
          else                      state_nx = GAP;
        end
      end
      GAP:    if (gap_end) state_nx = LOAD;
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_comb begin
    gen_clr   = 1'b0;
    gen_ena   = 1'b0;
    aes_start = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    trig      = (state == START) || (tcnt != '0);
    unique case (state)
      CLR:     gen_clr   = 1'b1;
      LOAD:    gen_ena   = 1'b1;
      START:   aes_start = 1'b1;
      OUT:     res_valid = 1'b1;
      FIN:     done      = 1'b1;
      default: ;
    endcase
  end

  // cnt restarts on every state change; only WAIT and GAP look at it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      tcnt        <= '0;
      idx         <= '0;
      last        <= '0;
      res_data    <= '0;
      res_idx     <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state_nx == state) ? cnt + 1'b1 : '0;
      if (abort)
        tcnt <= '0;
      else if (state == START)
        tcnt <= TW'(TRIG_HOLD - 1);
      else if (tcnt != '0)
        tcnt <= tcnt - 1'b1;
      if (!abort) begin
        if (state == IDLE && run) begin
          idx         <= '0;
          timeout_err <= 1'b0;
          if (num_vectors == 8'd0 || num_vectors > 8'd128)
            last <= 7'd127;
          else
            last <= 7'(num_vectors - 8'd1);
        end
        if (state == WAIT && aes_done) begin
          res_data <= aes_ct;
          res_idx  <= idx;
        end
        if (state == WAIT && !aes_done && wait_to)
          timeout_err <= 1'b1;
        if (hs && !last_v)
          idx <= idx + 1'b1;
      end
    end
  end

endmodule
